// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO management master: controller state
// encoding, Clause 22 / Clause 45 start and opcode values, command word
// field positions and the read/write frame classifier.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } mdio_state_e;

  // Start-of-frame codes
  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  // Clause 22 opcodes
  localparam logic [1:0] OP_C22_WR = 2'b01;
  localparam logic [1:0] OP_C22_RD = 2'b10;

  // Clause 45 opcodes
  localparam logic [1:0] OP_C45_ADDR  = 2'b00;
  localparam logic [1:0] OP_C45_WR    = 2'b01;
  localparam logic [1:0] OP_C45_RD    = 2'b11;
  localparam logic [1:0] OP_C45_RDINC = 2'b10;

  // Command word field positions (MSB of each field)
  localparam int TD_ST_MSB   = 31;
  localparam int TD_OP_MSB   = 29;
  localparam int TD_PHY_MSB  = 27;
  localparam int TD_REG_MSB  = 22;
  localparam int TD_TA_MSB   = 17;
  localparam int TD_DATA_MSB = 15;

  // Bit counts of the serial frame sections after the preamble
  localparam int HDR_BITS  = TD_ST_MSB - TD_TA_MSB;   // ST..REGAD = 14
  localparam int TA_BITS   = TD_TA_MSB - TD_DATA_MSB; // 2
  localparam int DATA_BITS = TD_DATA_MSB + 1;         // 16

  // A frame is a read when the PHY drives the turnaround and data bits.
  // ST=00 with Clause 45 disabled falls through to write-type.
  function automatic logic is_read_frame(input logic [31:0] td, input logic c45_en);
    logic [1:0] st;
    logic [1:0] op;
    logic       rd;
    st = td[TD_ST_MSB -: 2];
    op = td[TD_OP_MSB -: 2];
    rd = 1'b0;
    if (st == ST_C22) begin
      case (op)
        OP_C22_RD: rd = 1'b1;
        OP_C22_WR: rd = 1'b0;
        default:   rd = 1'b0;
      endcase
    end else if (c45_en && (st == ST_C45)) begin
      case (op)
        OP_C45_RD, OP_C45_RDINC: rd = 1'b1;
        OP_C45_ADDR, OP_C45_WR:  rd = 1'b0;
        default:                 rd = 1'b0;
      endcase
    end
    return rd;
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: while enabled, produces MDC low for CLK_DIV/2 clk cycles
// then high for CLK_DIV/2 cycles, plus single-cycle strobes marking the
// clk cycle at whose end MDC rises (o_rise) or falls (o_fall).
module mdio_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_mdc,
  output logic o_rise,
  output logic o_fall
);

  localparam int              CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   RISE_AT = CW'(CLK_DIV / 2 - 1);

  logic [CW-1:0] r_cnt;
  logic          r_mdc;

  // Phase counter and registered MDC; held at zero (MDC low) when disabled.
  always_ff @(posedge clk) begin
    if (!reset || !i_en) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == RISE_AT) r_mdc <= 1'b1;
    end
  end

  assign o_mdc  = r_mdc;
  assign o_rise = i_en && (r_cnt == RISE_AT);
  assign o_fall = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mdio_master_ctrl.sv
// MDIO management master. Serialises a 32-bit command word, preceded by an
// optional preamble, onto MDIO under a divided MDC. Output bits change only
// together with the MDC falling edge; read data is sampled with MDC rising.
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int PREAMBLE_LEN = 32,
  parameter int C45_EN       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        mdc,
  output logic        mdio_oe,
  output logic        mdio_out,
  output logic        busy
);

  localparam logic [4:0] PRE_LAST  = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] HDR_LAST  = 5'(HDR_BITS - 1);
  localparam logic [4:0] TA_LAST   = 5'(TA_BITS - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);

  mdio_state_e r_state;
  logic [31:0] r_tx;
  logic [15:0] r_rx;
  logic [4:0]  r_bitcnt;
  logic        r_rd;
  logic [15:0] r_rd_data;
  logic        r_data_rdy;
  logic        r_oe;
  logic        r_out;
  logic        r_busy;

  logic        w_clk_en;
  logic        w_mdc;
  logic        w_mdc_rise;
  logic        w_mdc_fall;
  logic        w_drv_bit;
  logic [31:0] w_tx_shift;

  // MDC runs only while bits are being transferred.
  assign w_clk_en   = (r_state != S_IDLE) && (r_state != S_DONE);
  // In TA/DATA of a read the line is released and mdio_out parks at 0.
  assign w_drv_bit  = r_rd ? 1'b0 : r_tx[31];
  assign w_tx_shift = {r_tx[30:0], 1'b0};

  mdio_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_clk_en),
    .o_mdc  (w_mdc),
    .o_rise (w_mdc_rise),
    .o_fall (w_mdc_fall)
  );

  // Frame sequencer: each MDC fall advances one bit and loads the next MDIO value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tx       <= '0;
      r_rx       <= '0;
      r_bitcnt   <= '0;
      r_rd       <= 1'b0;
      r_rd_data  <= '0;
      r_data_rdy <= 1'b0;
      r_oe       <= 1'b0;
      r_out      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_data_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mdio_start) begin
            r_rd     <= is_read_frame(t_data, C45_EN != 0);
            r_busy   <= 1'b1;
            r_bitcnt <= '0;
            r_rx     <= '0;
            r_oe     <= 1'b1;
            if (PREAMBLE_LEN > 0) begin
              r_state <= S_PRE;
              r_out   <= 1'b1;
              r_tx    <= t_data;
            end else begin
              r_state <= S_HDR;
              r_out   <= t_data[31];
              r_tx    <= {t_data[30:0], 1'b0};
            end
          end
        end
        S_PRE: begin
          if (w_mdc_fall) begin
            if (r_bitcnt == PRE_LAST) begin
              r_state  <= S_HDR;
              r_bitcnt <= '0;
              r_out    <= r_tx[31];
              r_tx     <= w_tx_shift;
            end else begin
              r_bitcnt <= r_bitcnt + 5'd1;
            end
          end
        end
        S_HDR: begin
          if (w_mdc_fall) begin
            if (r_bitcnt == HDR_LAST) begin
              r_state  <= S_TA;
              r_bitcnt <= '0;
              r_oe     <= !r_rd;
              r_out    <= w_drv_bit;
            end else begin
              r_bitcnt <= r_bitcnt + 5'd1;
              r_out    <= r_tx[31];
            end
            r_tx <= w_tx_shift;
          end
        end
        S_TA: begin
          if (w_mdc_fall) begin
            if (r_bitcnt == TA_LAST) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end else begin
              r_bitcnt <= r_bitcnt + 5'd1;
            end
            r_out <= w_drv_bit;
            r_tx  <= w_tx_shift;
          end
        end
        S_DATA: begin
          if (w_mdc_rise && r_rd) r_rx <= {r_rx[14:0], mdio_in};
          if (w_mdc_fall) begin
            if (r_bitcnt == DATA_LAST) begin
              r_state <= S_DONE;
              r_oe    <= 1'b0;
              r_out   <= 1'b0;
              if (r_rd) begin
                r_rd_data  <= r_rx;
                r_data_rdy <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 5'd1;
              r_out    <= w_drv_bit;
              r_tx     <= w_tx_shift;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign data_rdy = r_data_rdy;
  assign mdc      = w_mdc;
  assign mdio_oe  = r_oe;
  assign mdio_out = r_out;
  assign busy     = r_busy;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Scoreboard bench for mdio_master_ctrl: three instances cover the default
// configuration, Clause 45 disabled, and a preamble-less fast-MDC variant.
module tb_mdio_master_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] t_data;
  logic        mdio_in;
  int          sel;

  logic        start_a, start_b, start_c;
  logic [15:0] rd_a, rd_b, rd_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        mdc_a, mdc_b, mdc_c;
  logic        oe_a, oe_b, oe_c;
  logic        out_a, out_b, out_c;
  logic        busy_a, busy_b, busy_c;

  logic [15:0] mon_rd;
  logic        mon_rdy, mon_mdc, mon_oe, mon_out, mon_busy;

  logic [1:0]  q_bits[$];
  logic [15:0] q_rd[$];
  int          q_len[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          rise_cnt = 0;
  logic        phy_en;
  logic [15:0] phy_word;
  int          phy_pre;

  always #5 clk = ~clk;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  mdio_master_ctrl #(.CLK_DIV(4), .PREAMBLE_LEN(32), .C45_EN(1)) dut_a (
    .clk(clk), .reset(reset), .mdio_start(start_a), .t_data(t_data), .mdio_in(mdio_in),
    .rd_data(rd_a), .data_rdy(rdy_a), .mdc(mdc_a), .mdio_oe(oe_a), .mdio_out(out_a), .busy(busy_a));

  mdio_master_ctrl #(.CLK_DIV(4), .PREAMBLE_LEN(32), .C45_EN(0)) dut_b (
    .clk(clk), .reset(reset), .mdio_start(start_b), .t_data(t_data), .mdio_in(mdio_in),
    .rd_data(rd_b), .data_rdy(rdy_b), .mdc(mdc_b), .mdio_oe(oe_b), .mdio_out(out_b), .busy(busy_b));

  mdio_master_ctrl #(.CLK_DIV(2), .PREAMBLE_LEN(0), .C45_EN(1)) dut_c (
    .clk(clk), .reset(reset), .mdio_start(start_c), .t_data(t_data), .mdio_in(mdio_in),
    .rd_data(rd_c), .data_rdy(rdy_c), .mdc(mdc_c), .mdio_oe(oe_c), .mdio_out(out_c), .busy(busy_c));

  always_comb begin
    mon_rd = rd_a; mon_rdy = rdy_a; mon_mdc = mdc_a; mon_oe = oe_a; mon_out = out_a; mon_busy = busy_a;
    if (sel == 1) begin
      mon_rd = rd_b; mon_rdy = rdy_b; mon_mdc = mdc_b; mon_oe = oe_b; mon_out = out_b; mon_busy = busy_b;
    end else if (sel == 2) begin
      mon_rd = rd_c; mon_rdy = rdy_c; mon_mdc = mdc_c; mon_oe = oe_c; mon_out = out_c; mon_busy = busy_c;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {oe,out} per MDC rise for a frame, truncated to nmax bits.
  task automatic push_frame(input logic [31:0] td, input int pre, input logic rd, input int nmax);
    for (int i = 0; i < pre + 32; i++) begin
      logic [1:0] e;
      if (i < pre)                    e = 2'b11;
      else if (rd && (i >= pre + 14)) e = 2'b00;
      else                            e = {1'b1, td[31 - (i - pre)]};
      if (i < nmax) q_bits.push_back(e);
    end
  endtask

  // Monitor + PHY model: compares every MDC rise, data_rdy pulse and busy run.
  task automatic monitor();
    logic        prev_mdc;
    int          run;
    int          idx;
    logic [1:0]  eb;
    logic [15:0] er;
    int          el;
    prev_mdc = 1'b0;
    run      = 0;
    mdio_in  = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_mdc && !prev_mdc) begin
        if (q_bits.size() == 0) check("unexpected_mdc_rise", 32'd1, 32'd0);
        else begin
          eb = q_bits.pop_front();
          check($sformatf("bit%0d_oe_out", rise_cnt), 32'({mon_oe, mon_out}), 32'(eb));
        end
        rise_cnt++;
      end
      if (!mon_mdc && prev_mdc) begin
        idx = rise_cnt - (phy_pre + 16);
        if (phy_en && idx >= 0 && idx < 16) mdio_in = phy_word[15 - idx];
        else                                mdio_in = 1'b1;
      end
      if (mon_rdy) begin
        if (q_rd.size() == 0) check("unexpected_data_rdy", 32'd1, 32'd0);
        else begin
          er = q_rd.pop_front();
          check("rd_data", 32'(mon_rd), 32'(er));
        end
      end
      if (mon_busy) run++;
      else begin
        if (run > 0) begin
          if (q_len.size() == 0) check("unexpected_busy_run", 32'(run), 32'd0);
          else begin
            el = q_len.pop_front();
            if (el > 0) check("busy_len", 32'(run), 32'(el));
          end
        end
        run      = 0;
        rise_cnt = 0;
      end
      prev_mdc = mon_mdc;
    end
  endtask

  // Call at a negedge; the following posedge accepts the request.
  task automatic start_now(input logic [31:0] td);
    t_data = td;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (mon_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (mon_busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"}, 32'(mon_rd), 32'd0);
    check({tag, "_data_rdy"}, 32'(mon_rdy), 32'd0);
    check({tag, "_mdc"}, 32'(mon_mdc), 32'd0);
    check({tag, "_mdio_oe"}, 32'(mon_oe), 32'd0);
    check({tag, "_mdio_out"}, 32'(mon_out), 32'd0);
    check({tag, "_busy"}, 32'(mon_busy), 32'd0);
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    start    = 1'b0;
    t_data   = '0;
    sel      = 0;
    phy_en   = 1'b0;
    phy_word = '0;
    phy_pre  = 32;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Clause 22 write
    push_frame(32'h508A_ABCD, 32, 1'b0, 64);
    q_len.push_back(257);
    start_now(32'h508A_ABCD);
    wait_idle();

    // Clause 22 read, PHY returns 1234
    phy_en = 1'b1; phy_word = 16'h1234;
    push_frame(32'h6088_0000, 32, 1'b1, 64);
    q_rd.push_back(16'h1234);
    q_len.push_back(257);
    start_now(32'h6088_0000);
    wait_idle();

    // Clause 45 read, PHY returns BEEF
    phy_word = 16'hBEEF;
    push_frame(32'h3088_0000, 32, 1'b1, 64);
    q_rd.push_back(16'hBEEF);
    q_len.push_back(257);
    start_now(32'h3088_0000);
    wait_idle();

    // Write with a stray start mid-frame; rd_data must keep BEEF
    push_frame(32'h508A_ABCD, 32, 1'b0, 64);
    q_len.push_back(257);
    start_now(32'h508A_ABCD);
    repeat (20) @(negedge clk);
    start_now(32'h6088_0000);
    wait_idle();
    check("rd_data_hold", 32'(mon_rd), 32'h0000_BEEF);

    // Read aborted by reset after 40 bits, then an immediate write
    phy_word = 16'h1234;
    push_frame(32'h6088_0000, 32, 1'b1, 40);
    q_len.push_back(0);
    start_now(32'h6088_0000);
    n = 0;
    while (rise_cnt < 40 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rise_cnt < 40) check("rise40_timeout", 32'(rise_cnt), 32'd40);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    reset = 1'b1;
    push_frame(32'h508A_ABCD, 32, 1'b0, 64);
    q_len.push_back(257);
    start_now(32'h508A_ABCD);
    check("start_after_reset", 32'(mon_busy), 32'd1);
    wait_idle();
    check("rd_data_after_abort", 32'(mon_rd), 32'd0);

    // Clause 45 disabled: ST=00 frame is write-type
    sel = 1; phy_word = 16'hBEEF; phy_pre = 32;
    @(negedge clk);
    push_frame(32'h3088_0000, 32, 1'b0, 64);
    q_len.push_back(257);
    start_now(32'h3088_0000);
    wait_idle();

    // No preamble, CLK_DIV=2: back-to-back write then read
    sel = 2; phy_word = 16'h1234; phy_pre = 0;
    @(negedge clk);
    push_frame(32'h508A_ABCD, 0, 1'b0, 32);
    q_len.push_back(65);
    push_frame(32'h6088_0000, 0, 1'b1, 32);
    q_rd.push_back(16'h1234);
    q_len.push_back(65);
    start_now(32'h508A_ABCD);
    wait_idle();
    start_now(32'h6088_0000);
    check("b2b_accept", 32'(mon_busy), 32'd1);
    wait_idle();

    repeat (5) @(negedge clk);
    check("leftover_bits", 32'(q_bits.size()), 32'd0);
    check("leftover_rd", 32'(q_rd.size()), 32'd0);
    check("leftover_len", 32'(q_len.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdio_master_ctrl.md
MDIO_MASTER_CTRL -- requirements
Module: mdio_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per MDC period (even, >=2).
REQ-002 SHALL have parameter PREAMBLE_LEN, default 32, number of preamble '1' bits (0..32).
REQ-003 SHALL have parameter C45_EN, default 1, enables Clause 45 frames (ST=00).
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port mdio_start  input  1  single-cycle request to start a frame.
REQ-007 SHALL have port t_data  input  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD/PRTAD, [22:18] REGAD/DEVAD, [17:16] TA, [15:0] data.
REQ-008 SHALL have port mdio_in  input  1  serial data from PHY.
REQ-009 SHALL have port rd_data  output  16  captured read data.
REQ-010 SHALL have port data_rdy  output  1  one-cycle pulse, rd_data valid.
REQ-011 SHALL have port mdc  output  1  management clock.
REQ-012 SHALL have port mdio_oe  output  1  1 = controller drives MDIO.
REQ-013 SHALL have port mdio_out  output  1  serial data to PHY.
REQ-014 SHALL have port busy  output  1  frame in progress.

Function
REQ-015 SHALL accept mdio_start only in IDLE; t_data latched into a 32-bit shift register that cycle; mdio_start while busy ignored.
REQ-016 SHALL generate mdc only while busy: low for CLK_DIV/2 cycles, high for CLK_DIV/2 cycles; mdc low in IDLE.
REQ-017 SHALL update mdio_out/mdio_oe only on the clk cycle mdc falls (first bit on first low phase); mdio_in sampled on the cycle mdc rises.
REQ-018 SHALL sequence states IDLE -> PREAMBLE (PREAMBLE_LEN bits of 1, skipped if 0) -> HEADER (14 bits ST..REGAD, MSB first) -> TA -> DATA -> DONE -> IDLE.
REQ-019 SHALL classify read: ST=01 and OP=10, or (C45_EN and ST=00 and OP[1]=1); all else write/address.
REQ-020 SHALL in write frames drive TA from t_data[17:16] and 16 data bits, mdio_oe=1 throughout.
REQ-021 SHALL in read frames deassert mdio_oe from TA first bit through last data bit, mdio_out=0 while released, shift 16 sampled bits MSB first.
REQ-022 SHALL treat ST=00 with C45_EN=0 as write-type frame (no decoding error).
REQ-023 SHALL in DONE (one clk cycle) deassert mdio_oe, load rd_data and pulse data_rdy for reads; rd_data holds until next read completes.
REQ-024 SHALL keep busy high from the cycle after mdio_start accepted until DONE exits; frame length (PREAMBLE_LEN+32)*CLK_DIV cycles, +1 for DONE.
REQ-025 SHALL accept a new mdio_start the cycle busy falls (back-to-back frames, no extra gap).

Reset
REQ-026 SHALL, on clk rising with reset=0, force state IDLE, bit/divider counters 0, shift registers 0, and rd_data=0, data_rdy=0, mdc=0, mdio_oe=0, mdio_out=0, busy=0.
REQ-027 SHALL abort any frame on reset mid-operation, no data_rdy pulse, and accept mdio_start on first cycle with reset=1.

Structure
REQ-028 SHALL place state encoding, OP codes (C22 WR=01, RD=10; C45 ADDR=00, WR=01, RD=11, RDINC=10), ST codes and t_data field positions in shared package mdio_pkg.
REQ-029 SHALL implement MDC divider and rise/fall strobes in sub-module mdio_clk_gen (parameter CLK_DIV).

Verification
REQ-030 C22 write: CLK_DIV=4, PREAMBLE_LEN=32, t_data=32'h508A_ABCD -> 32 ones then 0101_00001_00010_10_1010101111001101 on mdio_out at mdc rise, mdio_oe=1, busy 257 cycles, no data_rdy.
REQ-031 C22 read: t_data=32'h6088_0000, PHY drives 16'h1234 -> mdio_oe=0 for last 18 bits, rd_data=16'h1234, data_rdy one cycle.
REQ-032 C45 read: t_data=32'h3088_0000 (ST=00, OP=11), PHY drives 16'hBEEF -> rd_data=16'hBEEF; same with C45_EN=0 -> write frame, mdio_oe=1 throughout, no data_rdy.
REQ-033 Reset mid-frame: reset=0 at bit 40 of a read -> next cycle all outputs 0, no data_rdy; subsequent write completes correctly.
REQ-034 mdio_start asserted during busy -> ignored; back-to-back start on busy-fall cycle -> second frame starts, PREAMBLE_LEN=0 frame = 32 mdc periods.
